// File: rtl/joy_serial_scan.sv
// Serial scanner for 74HC165-chained SNAC/DB15 adapters: drives load/shift clock,
// deserialises active-low button bits into active-high per-player words with presence.
module joy_serial_scan #(
    parameter int DIV     = 24,
    parameter int PLAYERS = 2,
    parameter int BITS    = 12,
    parameter int GAP     = 8
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      joy_data,
    output logic                      joy_clk,
    output logic                      joy_load,
    output logic [PLAYERS*BITS-1:0]   joystick,
    output logic [PLAYERS-1:0]        present,
    output logic                      valid,
    output logic                      changed
);

    localparam int TOTAL = PLAYERS * BITS;
    localparam int DW    = $clog2(DIV);
    localparam int KW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int GW    = $clog2(GAP + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(TOTAL - 1);
    localparam logic [GW-1:0] GAP_INIT = GW'(GAP);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [DW-1:0]        div_q, div_d;
    logic [KW-1:0]        k_q, k_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [TOTAL-1:0]     shift_q, shift_d;
    logic [TOTAL-1:0]     joystick_q, joystick_d;
    logic [PLAYERS-1:0]   present_q, present_d;
    logic                 valid_q, valid_d;
    logic                 changed_q, changed_d;
    logic                 joy_clk_q, joy_clk_d;
    logic                 joy_load_q, joy_load_d;
    logic                 tick_s;
    logic [PLAYERS-1:0]   pres_s;
    logic [TOTAL-1:0]     masked_s;

    // A player whose inverted samples are all ones had its line stuck low: no adapter.
    function automatic logic [PLAYERS-1:0] detect_present(input logic [TOTAL-1:0] frame);
        logic [PLAYERS-1:0] pres;
        pres = {PLAYERS{1'b0}};
        for (int p = 0; p < PLAYERS; p++) begin
            pres[p] = ~(&frame[p*BITS +: BITS]);
        end
        return pres;
    endfunction

    function automatic logic [TOTAL-1:0] mask_frame(input logic [TOTAL-1:0] frame,
                                                    input logic [PLAYERS-1:0] pres);
        logic [TOTAL-1:0] m;
        m = {TOTAL{1'b0}};
        for (int p = 0; p < PLAYERS; p++) begin
            m[p*BITS +: BITS] = pres[p] ? frame[p*BITS +: BITS] : {BITS{1'b0}};
        end
        return m;
    endfunction

    // Next-state logic: tick divider, scan FSM, frame latch and output strobes.
    always_comb begin
        tick_s     = (div_q == DIV_LAST);
        div_d      = tick_s ? {DW{1'b0}} : div_q + DW'(1);
        pres_s     = detect_present(shift_q);
        masked_s   = mask_frame(shift_q, pres_s);
        state_d    = state_q;
        k_d        = k_q;
        gap_d      = gap_q;
        shift_d    = shift_q;
        joystick_d = joystick_q;
        present_d  = present_q;
        valid_d    = 1'b0;
        changed_d  = 1'b0;
        if (tick_s) begin
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    k_d     = {KW{1'b0}};
                    state_d = S_SHIFT_LO;
                end
                S_SHIFT_LO: begin
                    shift_d[k_q] = ~joy_data;
                    state_d      = S_SHIFT_HI;
                end
                S_SHIFT_HI: begin
                    if (k_q < K_LAST) begin
                        k_d     = k_q + KW'(1);
                        state_d = S_SHIFT_LO;
                    end else begin
                        joystick_d = masked_s;
                        present_d  = pres_s;
                        valid_d    = 1'b1;
                        changed_d  = (masked_s != joystick_q);
                        gap_d      = GAP_INIT;
                        state_d    = S_GAP;
                    end
                end
                S_GAP: begin
                    // Leaving on the tick that would bring the count to zero gives exactly GAP ticks.
                    if (gap_q > GW'(1)) begin
                        gap_d = gap_q - GW'(1);
                    end else begin
                        gap_d   = {GW{1'b0}};
                        state_d = enable ? S_LOAD : S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        if (state_d == S_IDLE && !enable) begin
            joystick_d = {TOTAL{1'b0}};
            present_d  = {PLAYERS{1'b0}};
        end else begin
            joystick_d = joystick_d;
        end
        joy_clk_d  = (state_d == S_SHIFT_HI);
        joy_load_d = (state_d != S_LOAD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= S_IDLE;
            div_q      <= {DW{1'b0}};
            k_q        <= {KW{1'b0}};
            gap_q      <= {GW{1'b0}};
            shift_q    <= {TOTAL{1'b0}};
            joystick_q <= {TOTAL{1'b0}};
            present_q  <= {PLAYERS{1'b0}};
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
            joy_clk_q  <= 1'b0;
            joy_load_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            k_q        <= k_d;
            gap_q      <= gap_d;
            shift_q    <= shift_d;
            joystick_q <= joystick_d;
            present_q  <= present_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
            joy_clk_q  <= joy_clk_d;
            joy_load_q <= joy_load_d;
        end
    end

    assign joy_clk  = joy_clk_q;
    assign joy_load = joy_load_q;
    assign joystick = joystick_q;
    assign present  = present_q;
    assign valid    = valid_q;
    assign changed  = changed_q;

endmodule

// File: tb/tb_joy_serial_scan.sv
// Directed bench for joy_serial_scan with a 74HC165-style adapter model on the serial line.
module tb_joy_serial_scan;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic        joy_data, joy_clk, joy_load, valid, changed;
    logic [23:0] joystick;
    logic [1:0]  present;

    logic        enable2 = 1'b0;
    logic        joy_data2, joy_clk2, joy_load2, valid2, changed2;
    logic [15:0] joystick2;
    logic [0:0]  present2;

    logic [23:0] wire_pat  = 24'hFFFFFF;
    logic [23:0] sr        = 24'hFFFFFF;
    logic        clk_prev  = 1'b0;
    logic [15:0] wire_pat2 = 16'hFFFF;
    logic [15:0] sr2       = 16'hFFFF;
    logic        clk_prev2 = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [23:0] wire_v;
        logic [23:0] exp_js;
        logic [1:0]  exp_pres;
        logic        exp_chg;
    } vec_t;
    vec_t vecs [7];

    joy_serial_scan #(.DIV(4), .PLAYERS(2), .BITS(12), .GAP(8)) dut (
        .clk_sys(clk_sys), .reset(reset), .enable(enable), .joy_data(joy_data),
        .joy_clk(joy_clk), .joy_load(joy_load), .joystick(joystick),
        .present(present), .valid(valid), .changed(changed));

    joy_serial_scan #(.DIV(2), .PLAYERS(1), .BITS(16), .GAP(1)) dut2 (
        .clk_sys(clk_sys), .reset(reset), .enable(enable2), .joy_data(joy_data2),
        .joy_clk(joy_clk2), .joy_load(joy_load2), .joystick(joystick2),
        .present(present2), .valid(valid2), .changed(changed2));

    always #5 clk_sys = ~clk_sys;

    // Adapter models: parallel load while load is low, shift one bit per shift-clock rise.
    always @(posedge clk_sys) begin
        clk_prev  <= joy_clk;
        clk_prev2 <= joy_clk2;
        if (!joy_load) sr <= wire_pat;
        else if (joy_clk && !clk_prev) sr <= {1'b1, sr[23:1]};
        else sr <= sr;
        if (!joy_load2) sr2 <= wire_pat2;
        else if (joy_clk2 && !clk_prev2) sr2 <= {1'b1, sr2[15:1]};
        else sr2 <= sr2;
    end
    assign joy_data  = sr[0];
    assign joy_data2 = sr2[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk_sys); #1;
            if (valid) begin cyc = i; break; end
        end
    endtask

    task automatic wait_load(input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk_sys); #1;
            if (!joy_load) begin cyc = i; break; end
        end
    endtask

    task automatic wait_rises(input int count, output int ok);
        int   r;
        logic p;
        r  = 0;
        p  = joy_clk;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_sys); #1;
            if (joy_clk && !p) r++;
            p = joy_clk;
            if (r == count) begin ok = 1; break; end
        end
    endtask

    initial begin
        int cyc, bad, lw, rises, hi_run, bad_hi, vcyc, ok;
        logic pclk;

        vecs[0] = '{~24'h3F1A5C,              24'h3F1A5C, 2'b11, 1'b1};
        vecs[1] = '{~24'h3F1A5C,              24'h3F1A5C, 2'b11, 1'b0};
        vecs[2] = '{{12'h000, ~12'h001},      24'h000001, 2'b01, 1'b1};
        vecs[3] = '{24'h000000,               24'h000000, 2'b00, 1'b1};
        vecs[4] = '{24'hFFFFFF,               24'h000000, 2'b11, 1'b0};
        vecs[5] = '{~24'h000FFE,              24'h000FFE, 2'b11, 1'b1};
        vecs[6] = '{{~12'h800, 12'h000},      24'h800000, 2'b10, 1'b1};

        // Reset and idle behaviour
        repeat (10) @(posedge clk_sys);
        #1;
        check("rst_load", {31'd0, joy_load}, 32'd1);
        check("rst_clk", {31'd0, joy_clk}, 32'd0);
        check("rst_js", {8'd0, joystick}, 32'd0);
        check("rst_flags", {28'd0, present, valid, changed}, 32'd0);
        @(negedge clk_sys) reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk_sys); #1;
            if (joy_load !== 1'b1 || joy_clk !== 1'b0 || joystick !== 24'd0 ||
                present !== 2'd0 || valid !== 1'b0 || changed !== 1'b0) bad++;
        end
        check("idle_stable", bad, 32'd0);

        // Frame timing from a fresh reset with scanning enabled
        @(negedge clk_sys) begin reset = 1'b1; enable = 1'b1; end
        @(negedge clk_sys) reset = 1'b0;
        wait_load(50, cyc);
        check("first_load_cycle", cyc, 32'd4);
        lw = 1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_sys); #1;
            if (joy_load) break;
            lw++;
        end
        check("load_width", lw, 32'd4);
        rises = 0; hi_run = 0; bad_hi = 0; vcyc = -1; pclk = 1'b0;
        for (int n = 9; n < 600; n++) begin
            if (joy_clk) begin
                hi_run++;
                if (!pclk) rises++;
            end else if (hi_run > 0) begin
                if (hi_run != 4) bad_hi++;
                hi_run = 0;
            end
            pclk = joy_clk;
            if (valid) begin vcyc = n - 1; break; end
            @(posedge clk_sys); #1;
        end
        check("valid_cycle", vcyc, 32'd200);
        check("clk_rises", rises, 32'd24);
        check("clk_high_width", bad_hi, 32'd0);
        check("idle_js", {8'd0, joystick}, 32'd0);
        check("idle_pres", {30'd0, present}, 32'd3);
        check("idle_chg", {31'd0, changed}, 32'd0);
        wait_valid(400, cyc);
        check("frame_period", cyc, 32'd228);
        @(posedge clk_sys); #1;
        check("valid_width", {31'd0, valid}, 32'd0);

        // Data mapping and presence vectors
        for (int i = 0; i < 7; i++) begin
            wire_pat = vecs[i].wire_v;
            wait_valid(400, cyc);
            if (i > 0) check("vec_period", cyc, 32'd228);
            else check("vec_timeout", {31'd0, cyc > 0}, 32'd1);
            check($sformatf("vec%0d_js", i), {8'd0, joystick}, {8'd0, vecs[i].exp_js});
            check($sformatf("vec%0d_pres", i), {30'd0, present}, {30'd0, vecs[i].exp_pres});
            check($sformatf("vec%0d_chg", i), {31'd0, changed}, {31'd0, vecs[i].exp_chg});
        end

        // Reset during a frame aborts it
        wire_pat = ~24'h123456;
        wait_load(400, cyc);
        wait_rises(10, ok);
        check("rst_mid_reach", ok, 32'd1);
        @(negedge clk_sys) reset = 1'b1;
        @(posedge clk_sys); #1;
        check("rst_mid_js", {8'd0, joystick}, 32'd0);
        check("rst_mid_pins", {29'd0, joy_load, joy_clk, present != 2'd0}, 32'd4);
        @(negedge clk_sys) reset = 1'b0;
        wait_valid(400, cyc);
        check("rst_restart_valid", cyc, 32'd200);
        check("rst_restart_js", {8'd0, joystick}, 32'h00123456);
        check("rst_restart_chg", {31'd0, changed}, 32'd1);

        // Enable dropped mid-frame: frame completes, then idle clears
        wire_pat = ~24'h0F00F0;
        wait_load(400, cyc);
        wait_rises(10, ok);
        check("en_mid_reach", ok, 32'd1);
        enable = 1'b0;
        wait_valid(400, cyc);
        check("en_mid_valid", {31'd0, cyc > 0}, 32'd1);
        check("en_mid_js", {8'd0, joystick}, 32'h000F00F0);
        check("en_mid_pres", {30'd0, present}, 32'd3);
        repeat (31) @(posedge clk_sys);
        #1;
        check("en_gap_hold", {8'd0, joystick}, 32'h000F00F0);
        @(posedge clk_sys); #1;
        check("en_idle_js", {8'd0, joystick}, 32'd0);
        check("en_idle_pres", {30'd0, present}, 32'd0);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk_sys); #1;
            if (valid || !joy_load || joy_clk) bad++;
        end
        check("en_idle_quiet", bad, 32'd0);

        // Single 16-bit player, fastest clock, shortest gap
        wire_pat2 = ~16'h8000;
        enable2   = 1'b1;
        cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk_sys); #1;
            if (valid2) begin cyc = i; break; end
        end
        check("sweep_first", {31'd0, cyc > 0}, 32'd1);
        cyc = -1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk_sys); #1;
            if (valid2) begin cyc = i; break; end
        end
        check("sweep_period", cyc, 32'd68);
        check("sweep_js", {16'd0, joystick2}, 32'h00008000);
        check("sweep_pres", {31'd0, present2}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
